reflex_round_ctrl: RTL and testbench

//   Sequences one reflex-measurement session. Waits a random delay, lights the
//   LED, then times the player's press in milliseconds. Early presses and

---
 rtl/reflex_round_ctrl_if.sv | 37 +++
 rtl/reflex_round_ctrl.sv | 194 +++++++++++++++++++
 tb/tb_reflex_round_ctrl.sv | 257 +++++++++++++++++++++++++
 3 files changed

// File: rtl/reflex_round_ctrl_if.sv
// reflex_round_ctrl_if
//   Groups the session controller's handshake signals: player/LFSR inputs,
//   the error-counter handshake, and the display-side results.
//   Modports:
//     master - environment side: drives start, button, rand_delay, error_count
//     slave  - controller side: drives inc_errors, clr_errors, led_on,
//              reaction_ms, result_valid, best_ms, game_over, busy
//   Parameters: DELAY_W (rand_delay width), TIME_W (reaction/best width).
interface reflex_round_ctrl_if #(
  parameter int DELAY_W = 12,
  parameter int TIME_W  = 14
);
  logic               start;
  logic               button;
  logic [DELAY_W-1:0] rand_delay;
  logic [1:0]         error_count;
  logic               inc_errors;
  logic               clr_errors;
  logic               led_on;
  logic [TIME_W-1:0]  reaction_ms;
  logic               result_valid;
  logic [TIME_W-1:0]  best_ms;
  logic               game_over;
  logic               busy;

  modport master (
    output start, button, rand_delay, error_count,
    input  inc_errors, clr_errors, led_on, reaction_ms, result_valid,
           best_ms, game_over, busy
  );

  modport slave (
    input  start, button, rand_delay, error_count,
    output inc_errors, clr_errors, led_on, reaction_ms, result_valid,
           best_ms, game_over, busy
  );
endinterface

// File: rtl/reflex_round_ctrl.sv
// reflex_round_ctrl
//   Sequences one reflex-measurement session: waits a random delay, lights the
//   LED, then times the player's press in whole milliseconds. Early presses and
//   GO timeouts pulse the external 2-bit saturating error counter; the session
//   ends in OVER once that counter reaches MAX_ERRORS.
// Ports:
//   ck       in  clock, rising edge
//   reset_n  in  asynchronous active-low reset
//   bus      reflex_round_ctrl_if.slave:
//     start, button, rand_delay, error_count                       (inputs)
//     inc_errors, clr_errors, led_on, reaction_ms, result_valid,
//     best_ms, game_over, busy                                      (outputs)
// Build option:
//   BEST_TIME_EN - when defined, best_ms tracks the lowest reaction time since
//                  the session started; otherwise best_ms is constant all-ones.
module reflex_round_ctrl #(
  parameter int TICKS_PER_MS = 100000,
  parameter int DELAY_W      = 12,
  parameter int TIME_W       = 14,
  parameter int TIMEOUT_MS   = 2000,
  parameter int MAX_ERRORS   = 3
) (
  input  logic               ck,
  input  logic               reset_n,
  reflex_round_ctrl_if.slave bus
);

  localparam logic [2:0] S_IDLE = 3'd0;
  localparam logic [2:0] S_ARM  = 3'd1;
  localparam logic [2:0] S_WAIT = 3'd2;
  localparam logic [2:0] S_GO   = 3'd3;
  localparam logic [2:0] S_RES  = 3'd4;
  localparam logic [2:0] S_ERR  = 3'd5;
  localparam logic [2:0] S_OVER = 3'd6;

  localparam int              PRE_W    = (TICKS_PER_MS > 1) ? $clog2(TICKS_PER_MS) : 1;
  localparam logic [PRE_W-1:0] PRE_LAST = PRE_W'(TICKS_PER_MS - 1);
  localparam logic [TIME_W-1:0] TIME_MAX = '1;
  localparam logic [TIME_W-1:0] TIMEOUT  = TIME_W'(TIMEOUT_MS);
  localparam logic [1:0]       ERR_MAX  = 2'(MAX_ERRORS);
  localparam logic [1:0]       ERR_LAST = 2'(MAX_ERRORS - 1);

  logic [2:0]         state_q, state_d;
  logic [PRE_W-1:0]   pre_q;
  logic [TIME_W-1:0]  ms_q;
  logic [DELAY_W-1:0] delay_q, delay_d;
  logic [TIME_W-1:0]  react_q, react_d;
  logic               valid_q, valid_d;
  logic               inc_q, inc_d;
  logic               clr_q, clr_d;

  logic               tick;
  logic               entry;
  logic               start_ok;
  logic               press_ok;
  logic               inc_allowed;
  logic [TIME_W-1:0]  delay_last;

  assign tick        = (pre_q == PRE_LAST);
  assign entry       = (state_d != state_q);
  assign start_ok    = ((state_q == S_IDLE) || (state_q == S_OVER)) && bus.start;
  assign press_ok    = (state_q == S_GO) && bus.button;
  // A counter already at its limit gets no further pulse.
  assign inc_allowed = (bus.error_count < ERR_MAX);
  // delay_q is never zero, so this cannot underflow.
  assign delay_last  = TIME_W'(delay_q) - TIME_W'(1);

  // Next-state logic. Every transition lands in a different state, so a state
  // change is exactly a state entry and restarts the millisecond timebase.
  // Button checks precede timer checks: an early press beats delay expiry, and
  // a press on the timeout cycle still counts as a result.
  always_comb begin
    state_d = state_q;
    delay_d = delay_q;
    react_d = react_q;
    valid_d = 1'b0;
    inc_d   = 1'b0;
    clr_d   = 1'b0;
    case (state_q)
      S_IDLE, S_OVER: begin
        if (start_ok) begin
          state_d = S_ARM;
          clr_d   = 1'b1;
        end
      end
      S_ARM: begin
        if (!bus.button) begin
          delay_d = (bus.rand_delay == '0) ? DELAY_W'(1) : bus.rand_delay;
          state_d = S_WAIT;
        end
      end
      S_WAIT: begin
        if (bus.button) begin
          state_d = S_ERR;
          inc_d   = inc_allowed;
        end else if (tick && (ms_q == delay_last)) begin
          state_d = S_GO;
        end
      end
      S_GO: begin
        if (press_ok) begin
          state_d = S_RES;
          react_d = ms_q;
          valid_d = 1'b1;
        end else if (ms_q >= TIMEOUT) begin
          state_d = S_ERR;
          inc_d   = inc_allowed;
        end
      end
      S_RES: begin
        state_d = S_ARM;
      end
      S_ERR: begin
        // error_count still shows the pre-increment value during ERR.
        state_d = (bus.error_count >= ERR_LAST) ? S_OVER : S_ARM;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // State, result and pulse registers. Pulses are registered one cycle early
  // so they line up with the RES/ERR/first-ARM cycle they belong to.
  always_ff @(posedge ck or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= S_IDLE;
      delay_q <= DELAY_W'(1);
      react_q <= '0;
      valid_q <= 1'b0;
      inc_q   <= 1'b0;
      clr_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      delay_q <= delay_d;
      react_q <= react_d;
      valid_q <= valid_d;
      inc_q   <= inc_d;
      clr_q   <= clr_d;
    end
  end

  // Millisecond timebase: prescaler wraps at TICKS_PER_MS, the ms counter
  // saturates, and both restart on every state entry.
  always_ff @(posedge ck or negedge reset_n) begin
    if (!reset_n) begin
      pre_q <= '0;
      ms_q  <= '0;
    end else if (entry) begin
      pre_q <= '0;
      ms_q  <= '0;
    end else begin
      pre_q <= tick ? '0 : pre_q + PRE_W'(1);
      if (tick && (ms_q != TIME_MAX)) begin
        ms_q <= ms_q + TIME_W'(1);
      end
    end
  end

`ifdef BEST_TIME_EN
  logic [TIME_W-1:0] best_q, best_d;

  // Best time restarts with each session and only improves on strictly lower results.
  always_comb begin
    best_d = best_q;
    if (start_ok) begin
      best_d = '1;
    end else if (press_ok && (ms_q < best_q)) begin
      best_d = ms_q;
    end
  end

  always_ff @(posedge ck or negedge reset_n) begin
    if (!reset_n) begin
      best_q <= '1;
    end else begin
      best_q <= best_d;
    end
  end

  assign bus.best_ms = best_q;
`else
  assign bus.best_ms = '1;
`endif

  assign bus.inc_errors   = inc_q;
  assign bus.clr_errors   = clr_q;
  assign bus.result_valid = valid_q;
  assign bus.reaction_ms  = react_q;
  assign bus.led_on       = (state_q == S_GO);
  assign bus.game_over    = (state_q == S_OVER);
  assign bus.busy         = (state_q != S_IDLE) && (state_q != S_OVER);

endmodule

// File: tb/tb_reflex_round_ctrl.sv
// tb_reflex_round_ctrl
//   Directed bench for reflex_round_ctrl with TICKS_PER_MS=4, TIMEOUT_MS=20.
//   A table of per-step vectors walks a full session (valid result, early
//   press, press on delay expiry, timeout into OVER, restart); hand-written
//   sequences cover best-time tracking, zero delay, press before the first
//   tick, press on the timeout cycle, restart from OVER and reset mid-GO.
//   Honours BEST_TIME_EN for best_ms expectations.
module tb_reflex_round_ctrl;

  localparam int TICKS = 4;
  localparam logic [13:0] ALL_ONES = '1;
`ifdef BEST_TIME_EN
  localparam logic [13:0] BEST_AFTER_946 = 14'd4;
  localparam logic [13:0] BEST_AFTER_0   = 14'd0;
`else
  localparam logic [13:0] BEST_AFTER_946 = '1;
  localparam logic [13:0] BEST_AFTER_0   = '1;
`endif

  typedef struct {
    logic        start;
    logic        button;
    logic [11:0] randDelay;
    int          cycles;
    logic        expLed;
    logic        expBusy;
    logic        expOver;
    logic        expValid;
    logic        expInc;
    logic        expClr;
    logic [13:0] expReaction;
  } vecT;

  logic       ck;
  logic       resetN;
  logic [1:0] errCnt;
  int         checks;
  int         errors;
  vecT        vecs[$];

  reflex_round_ctrl_if #(.DELAY_W(12), .TIME_W(14)) bus ();

  reflex_round_ctrl #(
    .TICKS_PER_MS(TICKS),
    .DELAY_W(12),
    .TIME_W(14),
    .TIMEOUT_MS(20),
    .MAX_ERRORS(3)
  ) dut (
    .ck(ck),
    .reset_n(resetN),
    .bus(bus)
  );

  initial begin
    ck = 1'b0;
    forever #5 ck = ~ck;
  end

  // Stand-in for the external 2-bit saturating error counter.
  always @(posedge ck or negedge resetN) begin
    if (!resetN) begin
      errCnt <= 2'd0;
    end else if (bus.clr_errors) begin
      errCnt <= 2'd0;
    end else if (bus.inc_errors && (errCnt != 2'd3)) begin
      errCnt <= errCnt + 2'd1;
    end
  end

  assign bus.error_count = errCnt;

  task automatic checkOutput(input string name, input logic [31:0] actual,
                             input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got %0d expected %0d", name, actual, expected);
    end
  endtask

  task automatic addVec(input logic s, input logic b, input logic [11:0] rd,
                        input int cyc, input logic led, input logic busy,
                        input logic over, input logic valid, input logic inc,
                        input logic clr, input logic [13:0] react);
    vecT v;
    v.start = s; v.button = b; v.randDelay = rd; v.cycles = cyc;
    v.expLed = led; v.expBusy = busy; v.expOver = over; v.expValid = valid;
    v.expInc = inc; v.expClr = clr; v.expReaction = react;
    vecs.push_back(v);
  endtask

  task automatic step(input int n);
    repeat (n) @(posedge ck);
    #1;
  endtask

  task automatic applyStimulus(input vecT v);
    bus.start      = v.start;
    bus.button     = v.button;
    bus.rand_delay = v.randDelay;
    step(v.cycles);
  endtask

  task automatic checkVector(input int idx, input vecT v);
    checkOutput($sformatf("vec%0d led_on", idx), 32'(bus.led_on), 32'(v.expLed));
    checkOutput($sformatf("vec%0d busy", idx), 32'(bus.busy), 32'(v.expBusy));
    checkOutput($sformatf("vec%0d game_over", idx), 32'(bus.game_over), 32'(v.expOver));
    checkOutput($sformatf("vec%0d result_valid", idx), 32'(bus.result_valid), 32'(v.expValid));
    checkOutput($sformatf("vec%0d inc_errors", idx), 32'(bus.inc_errors), 32'(v.expInc));
    checkOutput($sformatf("vec%0d clr_errors", idx), 32'(bus.clr_errors), 32'(v.expClr));
    checkOutput($sformatf("vec%0d reaction_ms", idx), 32'(bus.reaction_ms), 32'(v.expReaction));
  endtask

  // Starts in ARM; runs one round and returns in ARM with button released.
  task automatic runRound(input logic [11:0] delay, input int pressMs, input string tag);
    int effDelay;
    effDelay = (delay == 12'd0) ? 1 : int'(delay);
    bus.rand_delay = delay;
    bus.button     = 1'b0;
    step(1);
    step(effDelay * TICKS - 1);
    checkOutput({tag, " led before delay"}, 32'(bus.led_on), 32'd0);
    step(1);
    checkOutput({tag, " led after delay"}, 32'(bus.led_on), 32'd1);
    step(pressMs * TICKS);
    bus.button = 1'b1;
    step(1);
    checkOutput({tag, " result_valid"}, 32'(bus.result_valid), 32'd1);
    checkOutput({tag, " reaction_ms"}, 32'(bus.reaction_ms), 32'(pressMs));
    checkOutput({tag, " inc_errors"}, 32'(bus.inc_errors), 32'd0);
    bus.button = 1'b0;
    step(1);
    checkOutput({tag, " result_valid drop"}, 32'(bus.result_valid), 32'd0);
  endtask

  // Starts in ARM; presses 1 ms into WAIT and checks the single error pulse.
  task automatic earlyPress(input logic expectOver, input string tag);
    bus.rand_delay = 12'd5;
    bus.button     = 1'b0;
    step(1 + TICKS);
    bus.button = 1'b1;
    step(1);
    checkOutput({tag, " inc_errors"}, 32'(bus.inc_errors), 32'd1);
    checkOutput({tag, " led_on"}, 32'(bus.led_on), 32'd0);
    bus.button = 1'b0;
    step(1);
    checkOutput({tag, " inc_errors drop"}, 32'(bus.inc_errors), 32'd0);
    checkOutput({tag, " game_over"}, 32'(bus.game_over), 32'(expectOver));
    checkOutput({tag, " busy"}, 32'(bus.busy), 32'(!expectOver));
  endtask

  initial begin
    checks = 0;
    errors = 0;
    resetN = 1'b0;
    bus.start = 1'b0;
    bus.button = 1'b0;
    bus.rand_delay = 12'd0;

    //      s  b  rd     cyc led bsy ovr vld inc clr react
    addVec(1, 0, 12'd5, 1,  0,  1,  0,  0,  0,  1,  14'd0);
    addVec(0, 0, 12'd5, 1,  0,  1,  0,  0,  0,  0,  14'd0);
    addVec(0, 0, 12'd5, 19, 0,  1,  0,  0,  0,  0,  14'd0);
    addVec(0, 0, 12'd5, 1,  1,  1,  0,  0,  0,  0,  14'd0);
    addVec(0, 0, 12'd5, 28, 1,  1,  0,  0,  0,  0,  14'd0);
    addVec(0, 1, 12'd5, 1,  0,  1,  0,  1,  0,  0,  14'd7);
    addVec(0, 1, 12'd5, 1,  0,  1,  0,  0,  0,  0,  14'd7);
    addVec(0, 1, 12'd5, 2,  0,  1,  0,  0,  0,  0,  14'd7);
    addVec(0, 0, 12'd5, 1,  0,  1,  0,  0,  0,  0,  14'd7);
    addVec(1, 0, 12'd5, 8,  0,  1,  0,  0,  0,  0,  14'd7);
    addVec(0, 1, 12'd5, 1,  0,  1,  0,  0,  1,  0,  14'd7);
    addVec(0, 0, 12'd5, 1,  0,  1,  0,  0,  0,  0,  14'd7);
    addVec(0, 0, 12'd2, 1,  0,  1,  0,  0,  0,  0,  14'd7);
    addVec(0, 0, 12'd2, 7,  0,  1,  0,  0,  0,  0,  14'd7);
    addVec(0, 1, 12'd2, 1,  0,  1,  0,  0,  1,  0,  14'd7);
    addVec(0, 0, 12'd2, 1,  0,  1,  0,  0,  0,  0,  14'd7);
    addVec(0, 0, 12'd0, 1,  0,  1,  0,  0,  0,  0,  14'd7);
    addVec(0, 0, 12'd0, 3,  0,  1,  0,  0,  0,  0,  14'd7);
    addVec(0, 0, 12'd0, 1,  1,  1,  0,  0,  0,  0,  14'd7);
    addVec(0, 0, 12'd0, 80, 1,  1,  0,  0,  0,  0,  14'd7);
    addVec(0, 0, 12'd0, 1,  0,  1,  0,  0,  1,  0,  14'd7);
    addVec(0, 0, 12'd0, 1,  0,  0,  1,  0,  0,  0,  14'd7);
    addVec(0, 0, 12'd0, 3,  0,  0,  1,  0,  0,  0,  14'd7);
    addVec(1, 0, 12'd0, 1,  0,  1,  0,  0,  0,  1,  14'd7);
    addVec(0, 1, 12'd0, 1,  0,  1,  0,  0,  0,  0,  14'd7);

    // Reset values.
    step(3);
    checkOutput("reset led_on", 32'(bus.led_on), 32'd0);
    checkOutput("reset busy", 32'(bus.busy), 32'd0);
    checkOutput("reset game_over", 32'(bus.game_over), 32'd0);
    checkOutput("reset result_valid", 32'(bus.result_valid), 32'd0);
    checkOutput("reset inc_errors", 32'(bus.inc_errors), 32'd0);
    checkOutput("reset clr_errors", 32'(bus.clr_errors), 32'd0);
    checkOutput("reset reaction_ms", 32'(bus.reaction_ms), 32'd0);
    checkOutput("reset best_ms", 32'(bus.best_ms), 32'(ALL_ONES));
    resetN = 1'b1;
    step(1);

    $display("[TB] applying %0d table vectors", vecs.size());
    for (int i = 0; i < vecs.size(); i++) begin
      applyStimulus(vecs[i]);
      checkVector(i, vecs[i]);
    end

    // Best-time tracking within the restarted session.
    runRound(12'd3, 9, "round9");
    runRound(12'd2, 4, "round4");
    runRound(12'd1, 6, "round6");
    checkOutput("best after 9,4,6", 32'(bus.best_ms), 32'(BEST_AFTER_946));

    // Zero delay acts as 1 ms, press before the first tick, press on timeout cycle.
    runRound(12'd0, 0, "round0");
    runRound(12'd1, 20, "roundTimeout");
    checkOutput("best after 0", 32'(bus.best_ms), 32'(BEST_AFTER_0));

    // Three errors end the session; restart from OVER.
    earlyPress(1'b0, "early1");
    earlyPress(1'b0, "early2");
    earlyPress(1'b1, "early3");
    bus.start = 1'b1;
    step(1);
    checkOutput("restart clr_errors", 32'(bus.clr_errors), 32'd1);
    checkOutput("restart inc_errors", 32'(bus.inc_errors), 32'd0);
    checkOutput("restart game_over", 32'(bus.game_over), 32'd0);
    checkOutput("restart busy", 32'(bus.busy), 32'd1);
    checkOutput("restart best_ms", 32'(bus.best_ms), 32'(ALL_ONES));
    bus.start  = 1'b0;
    bus.button = 1'b1;
    step(1);
    checkOutput("restart clr drop", 32'(bus.clr_errors), 32'd0);

    // Asynchronous reset in the middle of GO.
    bus.rand_delay = 12'd2;
    bus.button     = 1'b0;
    step(1 + 2 * TICKS);
    checkOutput("pre-reset led_on", 32'(bus.led_on), 32'd1);
    #2;
    resetN = 1'b0;
    #1;
    checkOutput("midGO reset led_on", 32'(bus.led_on), 32'd0);
    checkOutput("midGO reset busy", 32'(bus.busy), 32'd0);
    checkOutput("midGO reset best_ms", 32'(bus.best_ms), 32'(ALL_ONES));
    checkOutput("midGO reset game_over", 32'(bus.game_over), 32'd0);
    checkOutput("midGO reset inc_errors", 32'(bus.inc_errors), 32'd0);
    checkOutput("midGO reset clr_errors", 32'(bus.clr_errors), 32'd0);
    step(2);
    resetN = 1'b1;
    step(2);
    checkOutput("post-reset idle busy", 32'(bus.busy), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
